mcycle_ctrl: RTL and testbench



---
 rtl/mcycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl.sv
// -----------------------------------------------------------------------------
// mcycle_ctrl
//   Multi-cycle multiply/divide sequencer in the Execute stage. It takes one
//   operation per Start and runs WIDTH iterations of shift-add multiply or
//   restoring divide on operand magnitudes. It applies the sign correction
//   when it registers the result.
//
// Ports
//   CLK       in   rising-edge clock
//   Reset     in   asynchronous, active-high reset
//   Start     in   operation request (level, sampled on the rising edge)
//   MCycleOp  in   00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
//   Operand1  in   multiplicand / dividend
//   Operand2  in   multiplier / divisor
//   Result1   out  low product half / quotient
//   Result2   out  high product half / remainder
//   Busy      out  stall request to the hazard unit (combinational)
//   Done      out  one-cycle pulse, results valid
// -----------------------------------------------------------------------------
module mcycle_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return -x;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  // MUL: {upper accumulator, multiplier}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [WIDTH-1:0]   b_q, b_d;
  // Raw dividend, returned as the remainder on divide by zero
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;

  logic               is_signed;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign Busy    = (state_q == S_COMP) | (Start & (state_q != S_COMP));
  assign Done    = (state_q == S_DONE);
  assign Result1 = res1_q;
  assign Result2 = res2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    acc_d      = acc_q;
    b_d        = b_q;
    dividend_d = dividend_q;
    res1_d     = res1_q;
    res2_d     = res2_q;

    // Operand capture: magnitudes plus saved signs for signed ops
    is_signed = MCycleOp[0];
    neg_a     = is_signed & Operand1[WIDTH-1];
    neg_b     = is_signed & Operand2[WIDTH-1];
    mag_a     = neg_a ? neg_w(Operand1) : Operand1;
    mag_b     = neg_b ? neg_w(Operand2) : Operand2;

    // One multiply iteration: conditional add into the upper half (carry kept), shift right
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // One restoring-divide iteration: shift pair left, trial subtract
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    step = op_q[1] ? div_step : mul_step;

    // Sign correction applied to the final iteration's value
    prod_fix = (sign_a_q ^ sign_b_q) ? neg_2w(step) : step;
    quo_fix  = (sign_a_q ^ sign_b_q) ? neg_w(step[WIDTH-1:0]) : step[WIDTH-1:0];
    rem_fix  = sign_a_q ? neg_w(step[2*WIDTH-1:WIDTH]) : step[2*WIDTH-1:WIDTH];

    case (state_q)
      S_COMP: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          if (!op_q[1]) begin
            {res2_d, res1_d} = prod_fix;
          end else if (b_q == '0) begin
            res1_d = '1;
            res2_d = dividend_q;
          end else begin
            res1_d = quo_fix;
            res2_d = rem_fix;
          end
        end
      end
      default: begin
        // IDLE or DONE: a new Start is accepted in either
        if (Start) begin
          state_d    = S_COMP;
          cnt_d      = '0;
          op_d       = MCycleOp;
          sign_a_d   = neg_a;
          sign_b_d   = neg_b;
          dividend_d = Operand1;
          if (MCycleOp[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            b_d   = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            b_d   = mag_a;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      acc_q      <= '0;
      b_q        <= '0;
      dividend_q <= '0;
      res1_q     <= '0;
      res2_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      dividend_q <= dividend_d;
      res1_q     <= res1_d;
      res2_q     <= res2_d;
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
module tb_mcycle_ctrl;
  localparam int WIDTH = 32;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MCycleOp = 2'b00;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  mcycle_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on every Done; otherwise results must hold
  logic [31:0] held1 = '0;
  logic [31:0] held2 = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        held1 = '0;
        held2 = '0;
      end else if (Done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check32("result1", Result1, e.r1);
          check32("result2", Result2, e.r2);
          check32("latency_cycle", 32'(cyc), 32'(e.t0 + WIDTH));
          held1 = e.r1;
          held2 = e.r2;
        end
      end else begin
        check32("hold_result1", Result1, held1);
        check32("hold_result2", Result2, held2);
      end
    end
  end

  // One complete operation with Start for a single cycle; operands and op
  // are scrambled right after the accepting edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2);
    int n;
    @(negedge CLK);
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    #1;
    check32("busy_same_cycle", 32'(Busy), 32'd1);
    @(posedge CLK);
    #1;
    sb.push_back('{e1, e2, cyc});
    Start    = 1'b0;
    MCycleOp = ~op;
    Operand1 = ~a;
    Operand2 = b ^ 32'h5A5A_A5A5;
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!Busy) break;
      n++;
    end
    check32("busy_cycles", 32'(n), 32'(WIDTH + 1));
    check32("done_after_busy", 32'(Done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check32("reset_busy", 32'(Busy), 32'd0);
    check32("reset_done", 32'(Done), 32'd0);
    check32("reset_result1", Result1, 32'd0);
    check32("reset_result2", Result2, 32'd0);
    Reset = 1'b0;

    // Directed vectors
    run_op(2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd100,       32'd7,         32'd14,        32'd2);
    run_op(2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op(2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd20,        32'd0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

    // Start held through an op with operands changed mid-op; the second op
    // is accepted in the Done cycle.
    @(negedge CLK);
    MCycleOp = 2'b00;
    Operand1 = 32'd3;
    Operand2 = 32'd5;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    sb.push_back('{32'd15, 32'd0, cyc});
    MCycleOp = 2'b10;
    Operand1 = 32'd100;
    Operand2 = 32'd9;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (Done) begin
        found = 1;
        break;
      end
    end
    check32("b2b_first_done", 32'(found), 32'd1);
    check32("b2b_busy_in_done", 32'(Busy), 32'd1);
    @(posedge CLK);
    #1;
    sb.push_back('{32'd11, 32'd1, cyc});
    Start    = 1'b0;
    MCycleOp = 2'b01;
    Operand1 = 32'hDEAD_BEEF;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!Busy) begin
        found = 1;
        break;
      end
    end
    check32("b2b_busy_drops", 32'(found), 32'd1);
    check32("b2b_second_done", 32'(Done), 32'd1);

    // Reset pulsed at iteration 10 of a MUL
    @(negedge CLK);
    MCycleOp = 2'b01;
    Operand1 = 32'd12345;
    Operand2 = 32'hFFFF_FFFE;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    sb.push_back('{32'hFFFF_9F8E, 32'hFFFF_FFFF, cyc});
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    sb.delete();
    check32("midreset_busy", 32'(Busy), 32'd0);
    check32("midreset_done", 32'(Done), 32'd0);
    check32("midreset_result1", Result1, 32'd0);
    check32("midreset_result2", Result2, 32'd0);
    @(posedge CLK);
    #3;
    Reset = 1'b0;

    run_op(2'b01, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0);

    repeat (3) @(negedge CLK);
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
